// File: rtl/sccb_write_arbiter.sv
// sccb_write_arbiter
//   Arbitrates two SCCB register-write requesters (req0 = init sequencer,
//   req1 = runtime tuning) onto a single byte-oriented I2C master, and
//   sequences the three-byte write SLAVE_ADDR / reg addr / reg data.
//   A NACK on any byte ends the attempt with STOP and retries the whole
//   transaction after the idle gap, up to MAX_RETRY times.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req0/1, addr0/1,      write requests with register address / value,
//   data0/1               held by the requester until its grant
//   gnt0/1                1-cycle pulse when that request is captured
//   done0/1               1-cycle pulse when the write is ACKed and STOPped
//   err0/1                1-cycle pulse when the write is abandoned
//   start, stop           1-cycle commands to the I2C master
//   wr_data               byte for the I2C master, 0 when not presenting one
//   ack                   2'b11 ACK tick, 2'b10 NACK tick, 2'b0x ignored
//   i2c_state             I2C master state, 0 = idle
//   busy                  high whenever a transaction or gap is in progress
module sccb_write_arbiter #(
    parameter logic [7:0]  SLAVE_ADDR = 8'h42,
    parameter int unsigned GAP_CYCLES = 65536,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic       start,
    output logic       stop,
    output logic [7:0] wr_data,
    input  logic [1:0] ack,
    input  logic [3:0] i2c_state,
    output logic       busy
);

    localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);
    // The retry count must be able to reach MAX_RETRY+1 to detect exhaustion.
    localparam int unsigned RTRY_RAW = $clog2(MAX_RETRY + 2);
    localparam int unsigned RTRY_W   = (RTRY_RAW < 2) ? 2 : RTRY_RAW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                owner_q, owner_d;     // 0 = requester 0, 1 = requester 1
    logic                pending_q, pending_d; // retry due when the gap ends
    logic [RTRY_W-1:0]   retry_q, retry_d;
    logic [RTRY_W-1:0]   retry_inc;
    logic [GAP_W-1:0]    gap_q, gap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            owner_q   <= 1'b0;
            pending_q <= 1'b0;
            retry_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            owner_q   <= owner_d;
            pending_q <= pending_d;
            retry_q   <= retry_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        owner_d   = owner_q;
        pending_d = pending_q;
        retry_d   = retry_q;
        gap_d     = '0;
        retry_inc = retry_q + RTRY_W'(1);
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        wr_data   = '0;
        busy      = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (i2c_state == 4'd0 && (req0 || req1)) begin
                    owner_d   = !req0;
                    addr_d    = req0 ? addr0 : addr1;
                    data_d    = req0 ? data0 : data1;
                    retry_d   = '0;
                    pending_d = 1'b0;
                    gnt0      = req0;
                    gnt1      = !req0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                start   = 1'b1;
                wr_data = SLAVE_ADDR;
                state_d = S_ADDR;
            end
            S_ADDR, S_DATA, S_STOP: begin
                if (ack == 2'b11) begin
                    if (state_q == S_ADDR) begin
                        wr_data = addr_q;
                        state_d = S_DATA;
                    end else if (state_q == S_DATA) begin
                        wr_data = data_q;
                        state_d = S_STOP;
                    end else begin
                        stop      = 1'b1;
                        done0     = !owner_q;
                        done1     = owner_q;
                        retry_d   = '0;
                        pending_d = 1'b0;
                        state_d   = S_GAP;
                    end
                end else if (ack == 2'b10) begin
                    stop = 1'b1;
                    if (retry_inc <= RTRY_W'(MAX_RETRY)) begin
                        retry_d   = retry_inc;
                        pending_d = 1'b1;
                    end else begin
                        retry_d   = '0;
                        pending_d = 1'b0;
                        err0      = !owner_q;
                        err1      = owner_q;
                    end
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d   = pending_q ? S_START : S_IDLE;
                    pending_d = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are held quiet for the whole reset interval, including
        // any grant that a held request would otherwise produce.
        if (rst) begin
            gnt0    = 1'b0;
            gnt1    = 1'b0;
            done0   = 1'b0;
            done1   = 1'b0;
            err0    = 1'b0;
            err1    = 1'b0;
            start   = 1'b0;
            stop    = 1'b0;
            wr_data = '0;
            busy    = 1'b0;
        end
    end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// tb_sccb_write_arbiter
//   Directed bench for sccb_write_arbiter with a transaction-level model
//   (byte index + gap countdown) compared against the DUT every cycle,
//   plus literal expectations on pulse counts and byte sequences.
module tb_sccb_write_arbiter;

    localparam int G  = 4;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] addr0, addr1, data0, data1;
    logic       gnt0, gnt1, done0, done1, err0, err1, start, stop, busy;
    logic [7:0] wr_data;
    logic [1:0] ack;
    logic [3:0] i2c_state;

    sccb_write_arbiter #(
        .SLAVE_ADDR (8'h42),
        .GAP_CYCLES (G),
        .MAX_RETRY  (MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .start     (start),
        .stop      (stop),
        .wr_data   (wr_data),
        .ack       (ack),
        .i2c_state (i2c_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed-event totals (written only by the monitor).
    int tot_gnt0 = 0, tot_gnt1 = 0, tot_done0 = 0, tot_done1 = 0;
    int tot_err0 = 0, tot_err1 = 0, tot_start = 0;
    int wr_q[$];
    int gnt_q[$];

    // Transaction-level model state.
    bit       m_active;
    bit       m_need_start;
    int       m_owner;
    int       m_acked;
    int       m_tries;
    int       m_gap_left;
    bit [7:0] m_addr, m_data;

    always @(negedge clk) begin
        bit [8:0] e_v, d_v;
        bit [7:0] e_wr;
        e_v  = '0;
        e_wr = 8'h00;
        if (rst) begin
            m_active = 0; m_need_start = 0; m_acked = 0;
            m_tries = 0; m_gap_left = 0; m_owner = 0;
        end else begin
            // e_v bits: gnt0 gnt1 done0 done1 err0 err1 start stop busy
            e_v[0] = m_active || (m_gap_left > 0);
            if (m_gap_left > 0) begin
                m_gap_left--;
            end else if (!m_active) begin
                if (i2c_state == 4'd0 && (req0 || req1)) begin
                    m_owner      = req0 ? 0 : 1;
                    m_addr       = req0 ? addr0 : addr1;
                    m_data       = req0 ? data0 : data1;
                    m_active     = 1;
                    m_need_start = 1;
                    m_tries      = 0;
                    e_v[8 - m_owner] = 1'b1;
                end
            end else if (m_need_start) begin
                e_v[2]       = 1'b1;
                e_wr         = 8'h42;
                m_need_start = 0;
                m_acked      = 0;
            end else if (ack == 2'b11) begin
                if (m_acked == 0) e_wr = m_addr;
                else if (m_acked == 1) e_wr = m_data;
                else begin
                    e_v[1] = 1'b1;
                    e_v[6 - m_owner] = 1'b1;
                    m_active   = 0;
                    m_tries    = 0;
                    m_gap_left = G;
                end
                m_acked++;
            end else if (ack == 2'b10) begin
                e_v[1] = 1'b1;
                m_tries++;
                m_gap_left = G;
                if (m_tries <= MR) begin
                    m_need_start = 1;
                end else begin
                    e_v[4 - m_owner] = 1'b1;
                    m_active = 0;
                    m_tries  = 0;
                end
            end
        end

        d_v = {gnt0, gnt1, done0, done1, err0, err1, start, stop, busy};
        checks++;
        if (d_v !== e_v || wr_data !== e_wr) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t got flags=%b wr_data=%02h expected flags=%b wr_data=%02h",
                     $time, d_v, wr_data, e_v, e_wr);
        end

        if (gnt0) begin tot_gnt0++; gnt_q.push_back(0); end
        if (gnt1) begin tot_gnt1++; gnt_q.push_back(1); end
        if (done0) tot_done0++;
        if (done1) tot_done1++;
        if (err0)  tot_err0++;
        if (err1)  tot_err1++;
        if (start) tot_start++;
        if (wr_data != 8'h00) wr_q.push_back(int'(wr_data));
    end

    int last_gnt0 = 0, last_gnt1 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (tot_gnt0 != last_gnt0) begin req0 = 1'b0; last_gnt0 = tot_gnt0; end
        if (tot_gnt1 != last_gnt1) begin req1 = 1'b0; last_gnt1 = tot_gnt1; end
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic ackt(input logic [1:0] v);
        ack = v;
        tick();
        ack = 2'b00;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_not_busy(input int max);
        int n = 0;
        while (busy && n < max) begin tick(); n++; end
        chk("busy_drop_timeout", int'(busy), 0);
    endtask

    task automatic wait_gnt(input int which, input int max);
        int n = 0;
        int base;
        base = (which == 0) ? tot_gnt0 : tot_gnt1;
        while (((which == 0) ? tot_gnt0 : tot_gnt1) == base && n < max) begin
            tick(); n++;
        end
        chk("grant_timeout", ((which == 0) ? tot_gnt0 : tot_gnt1) - base, 1);
    endtask

    task automatic chk_bytes(input string name, input int base, input int exp[6], input int n);
        chk({name, "_count"}, wr_q.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < wr_q.size()) chk(name, wr_q[base + i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b_wr, b_st, b_d0, b_d1, b_e0, b_e1, b_g0, b_gq;
        int exp[6];

        rst = 1'b1; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
        ack = 2'b00; i2c_state = 4'd0;
        cyc(3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        rst = 1'b0;
        tick();

        // Single write from requester 1, with a 2'b01 tick that must be ignored.
        b_wr = wr_q.size(); b_st = tot_start; b_d1 = tot_done1;
        req1 = 1; addr1 = 8'h55; data1 = 8'h05;
        tick(); tick();
        ackt(2'b01);
        ackt(2'b11); tick();
        ackt(2'b11);
        ackt(2'b11);
        wait_not_busy(G + 4);
        exp = '{8'h42, 8'h55, 8'h05, 0, 0, 0};
        chk_bytes("single_bytes", b_wr, exp, 3);
        chk("single_starts", tot_start - b_st, 1);
        chk("single_done1", tot_done1 - b_d1, 1);

        // Simultaneous requests: req0 first, req1 only after the gap.
        b_wr = wr_q.size(); b_gq = gnt_q.size(); b_d0 = tot_done0; b_d1 = tot_done1;
        req0 = 1; addr0 = 8'h12; data0 = 8'h80;
        req1 = 1; addr1 = 8'h56; data1 = 8'h45;
        tick(); tick();
        ackt(2'b11); ackt(2'b11); ackt(2'b11);
        chk("simul_req1_waits", tot_gnt1 - last_gnt1, 0);
        wait_gnt(1, G + 4);
        tick();
        ackt(2'b11); ackt(2'b11); ackt(2'b11);
        wait_not_busy(G + 4);
        exp = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h56, 8'h45};
        chk_bytes("simul_bytes", b_wr, exp, 6);
        chk("simul_order_first", (gnt_q.size() > b_gq) ? gnt_q[b_gq] : -1, 0);
        chk("simul_order_second", (gnt_q.size() > b_gq + 1) ? gnt_q[b_gq + 1] : -1, 1);
        chk("simul_done0", tot_done0 - b_d0, 1);
        chk("simul_done1", tot_done1 - b_d1, 1);

        // One NACK on the data byte, then success.
        b_st = tot_start; b_d0 = tot_done0; b_e0 = tot_err0;
        req0 = 1; addr0 = 8'h21; data0 = 8'h33;
        tick(); tick();
        ackt(2'b11);
        ackt(2'b10);
        cyc(G + 1);
        ackt(2'b11); ackt(2'b11); ackt(2'b11);
        wait_not_busy(G + 4);
        chk("retry_starts", tot_start - b_st, 2);
        chk("retry_done0", tot_done0 - b_d0, 1);
        chk("retry_err0", tot_err0 - b_e0, 0);

        // Persistent NACK: initial attempt + MAX_RETRY retries, then err1.
        b_st = tot_start; b_d1 = tot_done1; b_e1 = tot_err1;
        req1 = 1; addr1 = 8'h77; data1 = 8'h88;
        tick(); tick();
        repeat (4) begin ackt(2'b10); cyc(G + 1); end
        wait_not_busy(G + 4);
        chk("exhaust_starts", tot_start - b_st, 4);
        chk("exhaust_err1", tot_err1 - b_e1, 1);
        chk("exhaust_done1", tot_done1 - b_d1, 0);

        // Reset while in DATA, then a fresh write.
        b_d0 = tot_done0; b_e0 = tot_err0; b_d1 = tot_done1;
        req0 = 1; addr0 = 8'h0A; data0 = 8'h0B;
        tick(); tick();
        ackt(2'b11);
        rst = 1'b1;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_stop", int'(stop), 0);
        chk("midreset_wr_data", int'(wr_data), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("midreset_no_done", tot_done0 - b_d0, 0);
        chk("midreset_no_err", tot_err0 - b_e0, 0);
        req1 = 1; addr1 = 8'h3C; data1 = 8'h4D;
        tick(); tick();
        ackt(2'b11); ackt(2'b11); ackt(2'b11);
        wait_not_busy(G + 4);
        chk("postreset_done1", tot_done1 - b_d1, 1);

        // Master not idle: no grant until i2c_state returns to 0.
        b_g0 = tot_gnt0;
        i2c_state = 4'd3;
        req0 = 1; addr0 = 8'h5A; data0 = 8'h6B;
        cyc(3);
        chk("master_busy_no_gnt", tot_gnt0 - b_g0, 0);
        i2c_state = 4'd0;
        wait_gnt(0, 4);
        tick();
        ackt(2'b11); ackt(2'b11); ackt(2'b11);
        wait_not_busy(G + 4);

        // req0 raised during a req1 transaction must not preempt it.
        b_g0 = tot_gnt0; b_d1 = tot_done1;
        req1 = 1; addr1 = 8'h11; data1 = 8'h22;
        tick(); tick();
        req0 = 1; addr0 = 8'h33; data0 = 8'h44;
        ackt(2'b11); ackt(2'b11); ackt(2'b11);
        chk("no_preempt_gnt0", tot_gnt0 - b_g0, 0);
        chk("no_preempt_done1", tot_done1 - b_d1, 1);
        wait_gnt(0, G + 4);
        tick();
        ackt(2'b11); ackt(2'b11); ackt(2'b11);
        wait_not_busy(G + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_write_arbiter.md
SCCB_WRITE_ARBITER -- requirements
Module: sccb_write_arbiter

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 8'h42, the SCCB write address sent as the first byte of every transaction.
REQ-002 SHALL have parameter GAP_CYCLES, default 65536, the number of idle clk cycles enforced after each STOP.
REQ-003 SHALL have parameter MAX_RETRY, default 3, the number of re-attempts after a NACK before the transaction is abandoned.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports req0 / req1, input, 1 bit each: write requests; req0 is the init sequencer, req1 is runtime tuning (brightness/contrast).
REQ-007 SHALL have ports addr0 / addr1, input, 8 bits each, and data0 / data1, input, 8 bits each: register address and register value for each requester.
REQ-008 SHALL have ports gnt0 / gnt1, output, 1 bit each: a 1-cycle pulse when that requester's addr/data are captured.
REQ-009 SHALL have ports done0 / done1, output, 1 bit each: a 1-cycle pulse when that requester's write has been ACKed and STOP issued.
REQ-010 SHALL have ports err0 / err1, output, 1 bit each: a 1-cycle pulse when that requester's write is abandoned after retries.
REQ-011 SHALL have port start, output, 1 bit: 1-cycle pulse to the I2C master to issue START.
REQ-012 SHALL have port stop, output, 1 bit: 1-cycle pulse to the I2C master to issue STOP.
REQ-013 SHALL have port wr_data, output, 8 bits: byte for the I2C master; it is 0 except in the start or ack-advance cycle.
REQ-014 SHALL have port ack, input, 2 bits: from the I2C master; 2'b11 means ACK tick, 2'b10 means NACK tick.
REQ-015 SHALL have port i2c_state, input, 4 bits: I2C master state; 0 means idle.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, START, ADDR, DATA, STOP, GAP.
REQ-018 In IDLE, when i2c_state==0 and req0 or req1 is high, SHALL grant with fixed priority (req0 over req1).
- Grant captures addr/data/owner.
- Grant pulses gntN in the same cycle.
- Next state is START.
REQ-019 In START, SHALL assert start=1 and wr_data=SLAVE_ADDR for exactly one cycle, then go to ADDR.
REQ-020 In ADDR, on ack==2'b11, SHALL drive wr_data=captured addr in that same cycle and go to DATA.
REQ-021 In DATA, on ack==2'b11, SHALL drive wr_data=captured data in that same cycle and go to STOP.
REQ-022 In STOP, on ack==2'b11, SHALL assert stop=1, pulse doneN for the owner, and go to GAP.
REQ-023 On ack==2'b10 in ADDR, DATA or STOP, SHALL handle the NACK as follows.
- Assert stop=1.
- Increment the 2-bit-minimum retry counter.
- If the count ≤ MAX_RETRY, go to GAP and then back to START with the same captured transaction.
- Otherwise pulse errN, clear the counter, and go to GAP.
REQ-024 In GAP, SHALL count GAP_CYCLES cycles, then go to IDLE or, for a pending retry, to START; the counter width is clog2(GAP_CYCLES+1).
REQ-025 SHALL ignore requests while not in IDLE; a requester holds reqN until gntN.
REQ-026 SHALL clear the retry counter on every new grant and on every done.
REQ-027 SHALL ignore ack==2'b0x in all states; ack ticks in IDLE/START/GAP have no effect.
REQ-028 When both requests rise in the same cycle, SHALL grant req0 only; req1 is served on the next IDLE.
REQ-029 A req0 arriving during a req1 transaction SHALL NOT preempt it.

Reset
REQ-030 On rst high (asynchronous), SHALL enter IDLE and clear all counters and captured registers.
REQ-031 During reset, SHALL drive start, stop, gnt*, done*, err* and busy to 0 and wr_data to 8'h00.
REQ-032 Reset mid-transaction SHALL abandon it with no done/err pulse; the I2C master is reset by the same rst.

Verification
REQ-033 Directed scenario, single write: req1 with addr1=8'h55, data1=8'h05 → gnt1 pulse, start with wr_data=8'h42, then 8'h55 and 8'h05 on successive ACKs, stop and done1 on the third ACK, busy low after GAP_CYCLES.
REQ-034 Directed scenario, simultaneous requests: req0 (8'h12/8'h80) and req1 (8'h56/8'h45) asserted in the same cycle → req0 completes first, then req1 is granted only after GAP.
REQ-035 Directed scenario, retry: NACK on the DATA byte once, then ACK → exactly 2 start pulses and one done0, no err0.
REQ-036 Directed scenario, retry exhaustion: persistent NACK with MAX_RETRY=3 → 4 start pulses, then an err1 pulse, then IDLE.
REQ-037 Directed scenario, reset mid-write: rst asserted in DATA → outputs zero immediately, no done; a fresh request afterwards completes normally.
REQ-038 Directed scenario, idle master: req while i2c_state!=0 → no grant until i2c_state returns to 0.
